cache_control_nway: RTL and testbench
=====================================

// Module: cache_control_nway
// PURPOSE
//  Control FSM for an NUM_WAYS-way set-associative, write-back, write-allocate L1 cache.
//  Sits between the CPU mem_* port and the pmem_* port; drives per-way load strobes into the cache datapath.
//  Adds tree pseudo-LRU replacement, invalid-way-first victim choice, and write-back of the victim way only.
//  Adds saturating hit and miss counters.
// PARAMETERS
//  NUM_WAYS  4   ways per set; power of two, 2..8
//  WAY_W     $clog2(NUM_WAYS)   way-index width; derived, not overridable
//  CNT_W     16  width of the hit and miss performance counters
// PORTS
//  clk              in   1           clock; all state updates on posedge
//  rst              in   1           synchronous reset, active-high
//  mem_read         in   1           CPU read request; level, held until mem_resp
//  mem_write        in   1           CPU write request; level, held until mem_resp
//  mem_byte_enable  in   2           CPU write byte lanes
//  mem_resp         out  1           one-cycle CPU completion pulse
//  hit_vec          in   NUM_WAYS    per-way tag-match AND valid for the indexed set
//  valid_vec        in   NUM_WAYS    per-way valid bits of the indexed set
//  dirty_vec        in   NUM_WAYS    per-way dirty bits of the indexed set
//  plru_out         in   NUM_WAYS-1  PLRU tree bits of the indexed set
//  load_plru        out  1           write plru_in into the set's PLRU array
//  plru_in          out  NUM_WAYS-1  updated PLRU tree bits
//  load_tag/load_data/load_valid/load_dirty  out  NUM_WAYS  one-hot per-way array write strobes
//  valid_in, dirty_in  out  1        value written on a load_valid / load_dirty strobe
//  data_in_sel      out  1           0: line from pmem_rdata; 1: CPU write merged into line
//  pmem_addr_sel    out  1           0: CPU address; 1: victim tag + set index (write-back)
//  wb_way_sel       out  WAY_W       way whose line/tag drives pmem_wdata and the write-back address
//  pmem_read, pmem_write  out  1     physical-memory requests; level, held until pmem_resp
//  pmem_resp        in   1           physical-memory completion pulse
//  hit_count, miss_count  out  CNT_W  saturating performance counters
// BEHAVIOUR
//  Reset: state=IDLE, victim_q=0, both counters=0. All outputs are 0 during the reset cycle and the cycle after.
//  A request arriving in a reset cycle is ignored; the CPU re-presents it.
//  States: IDLE, WRITE_BACK, ALLOCATE. Request = mem_read|mem_write. Both set together is treated as a read.
//  hit = |hit_vec. hway = lowest set index in hit_vec (multiple hits are illegal, but the result is still deterministic).
//  IDLE, request && hit:
//   - mem_resp=1 in the same cycle (zero-wait hit); load_plru=1; plru_in = PLRU touch(hway).
//   - A write additionally raises load_data[hway] with data_in_sel=1, and load_dirty[hway] with dirty_in=1.
//   - A write with mem_byte_enable==0 responds and touches PLRU but loads no data or dirty bit.
//   - hit_count++.
//  IDLE, request && !hit:
//   - Victim = lowest-index way with valid_vec==0; if all ways are valid, victim = PLRU victim(plru_out).
//   - victim_q <= victim; miss_count++.
//   - Next state = WRITE_BACK if valid_vec[victim] && dirty_vec[victim], else ALLOCATE.
//   - Only the victim's dirty bit is examined, never other ways.
//  WRITE_BACK:
//   - pmem_write=1, pmem_addr_sel=1, wb_way_sel=victim_q.
//   - On pmem_resp go to ALLOCATE.
//  ALLOCATE:
//   - pmem_read=1, data_in_sel=0.
//   - Strobes load_data/load_tag/load_valid/load_dirty[victim_q] are asserted only in the pmem_resp cycle, with valid_in=1 and dirty_in=0.
//   - On pmem_resp go to IDLE. The retried request then hits and responds one cycle later.
//  PLRU tree: node i has children 2i+1 / 2i+2; bit=0 means the victim lies in the left subtree.
//   - touch(w) sets every node on w's path to point away from w.
//   - NUM_WAYS=2: a single bit, 1 means way1 is the victim.
//  Counters saturate at all-ones; they never wrap.
//  mem_resp is never asserted outside IDLE. pmem_read and pmem_write are never asserted together.
//  victim_q is stable from the miss cycle through ALLOCATE exit. CPU address/data must be held until mem_resp.
//  Reset mid-WRITE_BACK or mid-ALLOCATE: abort to IDLE; pmem_* drop in the reset cycle. A partial line is never marked valid.
// STRUCTURE
//  cache_types package (lc3b_types): NUM_WAYS default constant; typedef cache_state_t enum {IDLE, WRITE_BACK, ALLOCATE}.
//  Sub-module plru_tree #(NUM_WAYS): purely combinational.
//   - Inputs: plru_out, touch_way. Outputs: victim_way, plru_next.
//   - Instantiated once; touch_way = hway in IDLE, victim_q in ALLOCATE.
//  The controller owns the FSM, victim_q, the counters and strobe decode.
// TESTING
//  1. NUM_WAYS=4, reset, then read hitting way2 (hit_vec=0100) -> mem_resp same cycle; load_plru=1; hit_count=1.
//  2. Miss with valid_vec=1011 -> victim_q=2; ALLOCATE with pmem_read held;
//     pmem_resp on the 3rd cycle -> load_*[2]=1 that cycle only; next IDLE cycle hits.
//  3. All ways valid, plru_out=3'b000, dirty_vec=0001 -> victim way0;
//     WRITE_BACK with wb_way_sel=0, pmem_addr_sel=1; then ALLOCATE; dirty_in=0.
//  4. All ways valid, dirty_vec=1110, PLRU victim way0 -> goes straight to ALLOCATE; no pmem_write.
//  5. Write hit way1 with byte_enable=01 -> load_data[1], data_in_sel=1, load_dirty[1]=1, dirty_in=1.
//     Same with byte_enable=00 -> no data or dirty load.
//  6. rst asserted in the 2nd ALLOCATE cycle -> pmem_read=0 and no load_valid strobe;
//     state IDLE; counters 0. CNT_W=2 with 5 hits -> hit_count stays 3.

Source files
------------

// File: rtl/cache_control_nway_pkg.sv
// Shared types and defaults for the N-way write-back cache controller.
package cache_control_nway_pkg;

  localparam int NUM_WAYS_DEF = 4;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } cache_state_t;

endpackage

// File: rtl/cache_control_nway_if.sv
// CPU-side and physical-memory-side handshake signals of the cache controller.
interface cache_control_nway_if;

  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

endinterface

// File: rtl/cache_control_nway_plru_tree.sv
// Combinational tree pseudo-LRU: victim lookup and touch update for one set.
module plru_tree
  import cache_control_nway_pkg::*;
#(
  parameter  int NUM_WAYS = NUM_WAYS_DEF,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] plru_out,
  input  logic [WAY_W-1:0]    touch_way,
  output logic [WAY_W-1:0]    victim_way,
  output logic [NUM_WAYS-2:0] plru_next
);

  // Walk root to leaf; node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
  always_comb begin : walk
    int v_node;
    int t_node;
    victim_way = '0;
    plru_next  = plru_out;
    v_node     = 0;
    t_node     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_way[WAY_W-1-l] = plru_out[v_node];
      v_node = 2 * v_node + 1 + (plru_out[v_node] ? 1 : 0);
      plru_next[t_node] = ~touch_way[WAY_W-1-l];
      t_node = 2 * t_node + 1 + (touch_way[WAY_W-1-l] ? 1 : 0);
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Write-back, write-allocate N-way cache control FSM with PLRU replacement
// and saturating hit/miss counters.
module cache_control_nway
  import cache_control_nway_pkg::*;
#(
  parameter  int NUM_WAYS = NUM_WAYS_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  cache_control_nway_if.slave bus,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [NUM_WAYS-2:0] plru_out,
  output logic                load_plru,
  output logic [NUM_WAYS-2:0] plru_in,
  output logic [NUM_WAYS-1:0] load_tag,
  output logic [NUM_WAYS-1:0] load_data,
  output logic [NUM_WAYS-1:0] load_valid,
  output logic [NUM_WAYS-1:0] load_dirty,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                data_in_sel,
  output logic                pmem_addr_sel,
  output logic [WAY_W-1:0]    wb_way_sel,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  localparam logic [NUM_WAYS-1:0] WAY_ONE = {{(NUM_WAYS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cache_state_t        r_state;
  cache_state_t        w_next_state;
  logic                r_rst_q;
  logic [WAY_W-1:0]    r_victim;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;
  logic                w_active;
  logic                w_req;
  logic                w_write;
  logic                w_hit;
  logic                w_hit_inc;
  logic                w_miss_inc;
  logic [WAY_W-1:0]    w_hway;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_plru_victim;
  logic [WAY_W-1:0]    w_victim;
  logic [WAY_W-1:0]    w_touch_way;
  logic [NUM_WAYS-2:0] w_plru_next;
  logic [NUM_WAYS-1:0] w_hway_oh;
  logic [NUM_WAYS-1:0] w_victim_oh;

  // The cycle after reset is kept quiet as well, so requests only count from then on.
  assign w_active    = ~rst & ~r_rst_q;
  assign w_req       = bus.mem_read | bus.mem_write;
  assign w_write     = bus.mem_write & ~bus.mem_read;
  assign w_hit       = |hit_vec;
  assign w_victim    = (&valid_vec) ? w_plru_victim : w_inv_way;
  assign w_touch_way = (r_state == ALLOCATE) ? r_victim : w_hway;
  assign w_hway_oh   = WAY_ONE << w_hway;
  assign w_victim_oh = WAY_ONE << r_victim;
  assign hit_count   = w_active ? r_hit_cnt  : '0;
  assign miss_count  = w_active ? r_miss_cnt : '0;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_out   (plru_out),
    .touch_way  (w_touch_way),
    .victim_way (w_plru_victim),
    .plru_next  (w_plru_next)
  );

  // Lowest-index hit way and lowest-index invalid way (scan high to low).
  always_comb begin
    w_hway    = '0;
    w_inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      w_hway    = hit_vec[i]    ? WAY_W'(i) : w_hway;
      w_inv_way = !valid_vec[i] ? WAY_W'(i) : w_inv_way;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state   = r_state;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    load_plru      = 1'b0;
    plru_in        = '0;
    load_tag       = '0;
    load_data      = '0;
    load_valid     = '0;
    load_dirty     = '0;
    valid_in       = 1'b0;
    dirty_in       = 1'b0;
    data_in_sel    = 1'b0;
    pmem_addr_sel  = 1'b0;
    wb_way_sel     = '0;
    if (w_active) begin
      case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            bus.mem_resp = 1'b1;
            load_plru    = 1'b1;
            plru_in      = w_plru_next;
            w_hit_inc    = 1'b1;
            if (w_write && (bus.mem_byte_enable != 2'b00)) begin
              load_data   = w_hway_oh;
              load_dirty  = w_hway_oh;
              data_in_sel = 1'b1;
              dirty_in    = 1'b1;
            end else begin
              data_in_sel = 1'b0;
            end
          end else if (w_req) begin
            w_miss_inc   = 1'b1;
            w_next_state = (valid_vec[w_victim] && dirty_vec[w_victim]) ? WRITE_BACK : ALLOCATE;
          end else begin
            w_next_state = IDLE;
          end
        end
        WRITE_BACK: begin
          bus.pmem_write = 1'b1;
          pmem_addr_sel  = 1'b1;
          wb_way_sel     = r_victim;
          w_next_state   = bus.pmem_resp ? ALLOCATE : WRITE_BACK;
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            load_tag     = w_victim_oh;
            load_data    = w_victim_oh;
            load_valid   = w_victim_oh;
            load_dirty   = w_victim_oh;
            valid_in     = 1'b1;
            load_plru    = 1'b1;
            plru_in      = w_plru_next;
            w_next_state = IDLE;
          end else begin
            w_next_state = ALLOCATE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end else begin
      w_next_state = IDLE;
    end
  end

  // State, victim capture and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rst_q    <= 1'b1;
      r_victim   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_rst_q <= 1'b0;
      if (w_miss_inc) begin
        r_victim <= w_victim;
      end
      if (w_hit_inc && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNT_ONE;
      end
      if (w_miss_inc && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Scoreboard bench for cache_control_nway: a 4-way/16-bit instance and a
// 4-way/2-bit-counter instance driven in lockstep.
module tb_cache_control_nway;
  import cache_control_nway_pkg::*;

  typedef struct packed {
    logic        mem_resp;
    logic        load_plru;
    logic [2:0]  plru_in;
    logic [3:0]  load_tag;
    logic [3:0]  load_data;
    logic [3:0]  load_valid;
    logic [3:0]  load_dirty;
    logic        valid_in;
    logic        dirty_in;
    logic        data_in_sel;
    logic        pmem_addr_sel;
    logic [1:0]  wb_way_sel;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_control_nway_if bus_a ();
  cache_control_nway_if bus_b ();

  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [2:0] plru_out;

  logic        load_plru_a, valid_in_a, dirty_in_a, data_in_sel_a, pmem_addr_sel_a;
  logic [2:0]  plru_in_a;
  logic [3:0]  load_tag_a, load_data_a, load_valid_a, load_dirty_a;
  logic [1:0]  wb_way_sel_a;
  logic [15:0] hit_count_a, miss_count_a;

  logic        load_plru_b, valid_in_b, dirty_in_b, data_in_sel_b, pmem_addr_sel_b;
  logic [2:0]  plru_in_b;
  logic [3:0]  load_tag_b, load_data_b, load_valid_b, load_dirty_b;
  logic [1:0]  wb_way_sel_b;
  logic [1:0]  hit_count_b, miss_count_b;

  cache_control_nway #(.NUM_WAYS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_out(plru_out),
    .load_plru(load_plru_a), .plru_in(plru_in_a),
    .load_tag(load_tag_a), .load_data(load_data_a), .load_valid(load_valid_a), .load_dirty(load_dirty_a),
    .valid_in(valid_in_a), .dirty_in(dirty_in_a), .data_in_sel(data_in_sel_a),
    .pmem_addr_sel(pmem_addr_sel_a), .wb_way_sel(wb_way_sel_a),
    .hit_count(hit_count_a), .miss_count(miss_count_a)
  );

  cache_control_nway #(.NUM_WAYS(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru_out(plru_out),
    .load_plru(load_plru_b), .plru_in(plru_in_b),
    .load_tag(load_tag_b), .load_data(load_data_b), .load_valid(load_valid_b), .load_dirty(load_dirty_b),
    .valid_in(valid_in_b), .dirty_in(dirty_in_b), .data_in_sel(data_in_sel_b),
    .pmem_addr_sel(pmem_addr_sel_b), .wb_way_sel(wb_way_sel_b),
    .hit_count(hit_count_b), .miss_count(miss_count_b)
  );

  snap_t obs_a, obs_b;
  assign obs_a = {bus_a.mem_resp, load_plru_a, plru_in_a, load_tag_a, load_data_a, load_valid_a,
                  load_dirty_a, valid_in_a, dirty_in_a, data_in_sel_a, pmem_addr_sel_a,
                  wb_way_sel_a, bus_a.pmem_read, bus_a.pmem_write, hit_count_a, miss_count_a};
  assign obs_b = {bus_b.mem_resp, load_plru_b, plru_in_b, load_tag_b, load_data_b, load_valid_b,
                  load_dirty_b, valid_in_b, dirty_in_b, data_in_sel_b, pmem_addr_sel_b,
                  wb_way_sel_b, bus_b.pmem_read, bus_b.pmem_write,
                  {14'd0, hit_count_b}, {14'd0, miss_count_b}};

  int    n_vec  = 0;
  int    n_miss = 0;
  int    m_hits = 0;
  int    m_miss = 0;
  snap_t exp_q[$];
  string tag_q[$];

  task automatic check_vec(input string tag, input snap_t got, input snap_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  // Reference PLRU touch for 4 ways, written as an explicit table.
  function automatic logic [2:0] touch4(input int w, input logic [2:0] p);
    case (w)
      0:       return {p[2], 1'b1, 1'b1};
      1:       return {p[2], 1'b0, 1'b1};
      2:       return {1'b1, p[1], 1'b0};
      3:       return {1'b0, p[1], 1'b0};
      default: return p;
    endcase
  endfunction

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  function automatic snap_t base();
    snap_t s;
    s            = '0;
    s.hit_count  = 16'(m_hits);
    s.miss_count = 16'(m_miss);
    return s;
  endfunction

  function automatic snap_t hit_exp(input int w, input logic [2:0] p);
    snap_t s;
    s           = base();
    s.mem_resp  = 1'b1;
    s.load_plru = 1'b1;
    s.plru_in   = touch4(w, p);
    return s;
  endfunction

  function automatic snap_t fill_exp(input int w, input logic [2:0] p);
    snap_t s;
    s            = base();
    s.pmem_read  = 1'b1;
    s.load_tag   = oh(w);
    s.load_data  = oh(w);
    s.load_valid = oh(w);
    s.load_dirty = oh(w);
    s.valid_in   = 1'b1;
    s.load_plru  = 1'b1;
    s.plru_in    = touch4(w, p);
    return s;
  endfunction

  function automatic snap_t wb_exp(input int w);
    snap_t s;
    s               = base();
    s.pmem_write    = 1'b1;
    s.pmem_addr_sel = 1'b1;
    s.wb_way_sel    = 2'(w);
    return s;
  endfunction

  task automatic drive_cpu(input logic rd, input logic wr, input logic [1:0] be);
    bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_byte_enable = be;
    bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.mem_byte_enable = be;
  endtask

  task automatic set_pr(input logic v);
    bus_a.pmem_resp = v;
    bus_b.pmem_resp = v;
  endtask

  task automatic set_set(input logic [3:0] h, input logic [3:0] v, input logic [3:0] d, input logic [2:0] p);
    hit_vec = h; valid_vec = v; dirty_vec = d; plru_out = p;
  endtask

  // Push the expectation for both instances, then pop and compare mid-cycle.
  task automatic apply(input string tag, input snap_t want);
    snap_t want_b;
    want_b            = want;
    want_b.hit_count  = (want == '0) ? 16'd0 : {14'd0, sat2(m_hits)};
    want_b.miss_count = (want == '0) ? 16'd0 : {14'd0, sat2(m_miss)};
    exp_q.push_back(want);   tag_q.push_back({tag, "_a"});
    exp_q.push_back(want_b); tag_q.push_back({tag, "_b"});
    @(negedge clk);
    check_vec(tag_q.pop_front(), obs_a, exp_q.pop_front());
    check_vec(tag_q.pop_front(), obs_b, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_pr(1'b0);
    set_set(4'b0100, 4'b1111, 4'b0000, 3'b000);
    apply("rst0", '0);
    apply("rst1", '0);
    rst = 1'b0;
    apply("post_rst", '0);

    // Read hit way2.
    apply("t1_hit", hit_exp(2, 3'b000)); m_hits++;
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t1_idle", base());

    // Miss with an invalid way2; other ways dirty but never examined.
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_set(4'b0000, 4'b1011, 4'b1011, 3'b000);
    apply("t2_miss", base()); m_miss++;
    apply("t2_alloc1", {base()} | snap_t'({16'd0, 32'd0} | 65'h0) | pread());
    apply("t2_alloc2", pread());
    set_pr(1'b1);
    apply("t2_fill", fill_exp(2, 3'b000));
    set_pr(1'b0);
    hit_vec = 4'b0100;
    apply("t2_retry", hit_exp(2, 3'b000)); m_hits++;
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t2_idle", base());

    // All valid, PLRU victim way0 is dirty: write back then allocate.
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_set(4'b0000, 4'b1111, 4'b0001, 3'b000);
    apply("t3_miss", base()); m_miss++;
    apply("t3_wb1", wb_exp(0));
    set_pr(1'b1);
    apply("t3_wb2", wb_exp(0));
    apply("t3_fill", fill_exp(0, 3'b000));
    set_pr(1'b0);
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t3_idle", base());

    // Victim way0 clean, others dirty: straight to allocate.
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_set(4'b0000, 4'b1111, 4'b1110, 3'b000);
    apply("t4_miss", base()); m_miss++;
    apply("t4_alloc", pread());
    set_pr(1'b1);
    apply("t4_fill", fill_exp(0, 3'b000));
    set_pr(1'b0);

    // PLRU 101 selects way3, which is dirty.
    set_set(4'b0000, 4'b1111, 4'b1000, 3'b101);
    apply("t4b_miss", base()); m_miss++;
    set_pr(1'b1);
    apply("t4b_wb", wb_exp(3));
    apply("t4b_fill", fill_exp(3, 3'b101));
    set_pr(1'b0);
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t4b_idle", base());

    // Write hits on way1 with and without byte lanes.
    drive_cpu(1'b0, 1'b1, 2'b01);
    set_set(4'b0010, 4'b1111, 4'b0000, 3'b000);
    apply("t5_wr", wr_exp(1, 3'b000)); m_hits++;
    drive_cpu(1'b0, 1'b1, 2'b00);
    apply("t5_wr_be0", hit_exp(1, 3'b000)); m_hits++;
    // Read+write together acts as a read; double hit resolves to way1.
    drive_cpu(1'b1, 1'b1, 2'b11);
    set_set(4'b1010, 4'b1111, 4'b0000, 3'b111);
    apply("t5_rdwr", hit_exp(1, 3'b111)); m_hits++;

    // Reset in the second allocate cycle aborts the fill.
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_set(4'b0000, 4'b1011, 4'b0000, 3'b000);
    apply("t6_miss", base()); m_miss++;
    apply("t6_alloc1", pread());
    rst = 1'b1;
    set_pr(1'b1);
    apply("t6_rst", '0);
    m_hits = 0; m_miss = 0;
    rst = 1'b0;
    set_pr(1'b0);
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t6_post", '0);
    drive_cpu(1'b1, 1'b0, 2'b00);
    set_set(4'b0001, 4'b1111, 4'b0000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      apply($sformatf("t6_sat%0d", i), hit_exp(0, 3'b000)); m_hits++;
    end
    drive_cpu(1'b0, 1'b0, 2'b00);
    apply("t6_final", base());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  function automatic snap_t pread();
    snap_t s;
    s           = base();
    s.pmem_read = 1'b1;
    return s;
  endfunction

  function automatic snap_t wr_exp(input int w, input logic [2:0] p);
    snap_t s;
    s             = hit_exp(w, p);
    s.load_data   = oh(w);
    s.load_dirty  = oh(w);
    s.data_in_sel = 1'b1;
    s.dirty_in    = 1'b1;
    return s;
  endfunction

endmodule
